ifu: RTL

Instruction fetch unit for the single-issue NPC core. It holds the program counter, issues one instruction-memory request at a time, and presents each fetched 32-bit instruction with its PC to decode over a valid/ready handshake. Decode slices `id_instr` into the immediate generator and register-file read ports. Redirects from execute (branch, jump, trap) take priority over the in-flight fetch, and any stale response is discarded.

---
 rtl/ifu.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, keeps at most one instruction-memory request
// in flight and hands each fetched word with its PC to decode over valid/ready.
module ifu #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_fault
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t      state_r;
    state_t      norm_next_s;
    state_t      redir_next_s;
    state_t      next_state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] ir_instr_r;
    logic [31:0] ir_pc_r;
    logic        ir_fault_r;
    logic        ir_load_s;
    logic        ir_we_s;
    logic [31:0] ir_instr_s;
    logic        ir_fault_s;
    logic        pc_inc_s;
    logic        aligned_s;
    logic        accept_s;

    // A misaligned PC never reaches memory, so it can never be accepted either.
    assign aligned_s = (pc_r[1:0] == 2'b00);
    assign accept_s  = (state_r == REQ) && aligned_s && imem_req_ready;
    assign ir_we_s   = ir_load_s && !redirect_valid;

    // Normal (no redirect) transitions and instruction-register load data.
    always_comb begin
        norm_next_s = state_r;
        ir_load_s   = 1'b0;
        ir_instr_s  = NOP_INSTR;
        ir_fault_s  = 1'b0;
        pc_inc_s    = 1'b0;
        case (state_r)
            IDLE: norm_next_s = REQ;
            REQ: begin
                if (!aligned_s) begin
                    ir_load_s   = 1'b1;
                    ir_fault_s  = 1'b1;
                    norm_next_s = HOLD;
                end else if (imem_req_ready) begin
                    norm_next_s = WAIT;
                end else begin
                    norm_next_s = REQ;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    ir_load_s   = 1'b1;
                    ir_instr_s  = imem_rsp_err ? NOP_INSTR : imem_rsp_data;
                    ir_fault_s  = imem_rsp_err;
                    norm_next_s = HOLD;
                end else begin
                    norm_next_s = WAIT;
                end
            end
            HOLD: begin
                if (id_ready) begin
                    pc_inc_s    = 1'b1;
                    norm_next_s = REQ;
                end else begin
                    norm_next_s = HOLD;
                end
            end
            DROP: norm_next_s = imem_rsp_valid ? REQ : DROP;
            default: norm_next_s = IDLE;
        endcase
    end

    // Redirect transitions: any request already accepted must be drained through DROP.
    always_comb begin
        redir_next_s = IDLE;
        case (state_r)
            IDLE:    redir_next_s = REQ;
            REQ:     redir_next_s = accept_s ? DROP : REQ;
            WAIT:    redir_next_s = imem_rsp_valid ? REQ : DROP;
            HOLD:    redir_next_s = REQ;
            DROP:    redir_next_s = DROP;
            default: redir_next_s = IDLE;
        endcase
    end

    // Redirect overrides both the state transition and the PC update.
    always_comb begin
        next_state_s = redirect_valid ? redir_next_s : norm_next_s;
        if (redirect_valid) begin
            pc_next_s = redirect_pc;
        end else if (pc_inc_s) begin
            pc_next_s = pc_r + 32'd4;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // State, PC and instruction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            ir_instr_r <= NOP_INSTR;
            ir_pc_r    <= RESET_PC;
            ir_fault_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            pc_r    <= pc_next_s;
            if (ir_we_s) begin
                ir_instr_r <= ir_instr_s;
                ir_pc_r    <= pc_r;
                ir_fault_r <= ir_fault_s;
            end
        end
    end

    assign imem_req_valid = (state_r == REQ) && aligned_s;
    assign imem_req_addr  = pc_r;
    assign id_valid       = (state_r == HOLD);
    assign id_instr       = ir_instr_r;
    assign id_pc          = ir_pc_r;
    assign id_fault       = ir_fault_r;

endmodule
